// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes, FSM states and window slot indices
// for the parametrised LCD image controller.
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_WRITE   = 4'd0;
  localparam logic [3:0] CMD_UP      = 4'd1;
  localparam logic [3:0] CMD_DOWN    = 4'd2;
  localparam logic [3:0] CMD_LEFT    = 4'd3;
  localparam logic [3:0] CMD_RIGHT   = 4'd4;
  localparam logic [3:0] CMD_AVG     = 4'd5;
  localparam logic [3:0] CMD_MIRX    = 4'd6;
  localparam logic [3:0] CMD_MIRY    = 4'd7;
  localparam logic [3:0] CMD_MAX     = 4'd8;
  localparam logic [3:0] CMD_MIN     = 4'd9;
  localparam logic [3:0] CMD_ROT_CW  = 4'd10;
  localparam logic [3:0] CMD_ROT_CCW = 4'd11;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator; rotate paths exist only
// when LCD_CTRL_ROTATE_EN is defined.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [3:0]            cmd_i,
  input  logic [3:0][PIX_W-1:0] win_i,
  output logic [3:0][PIX_W-1:0] win_o
);

  logic [PIX_W+1:0] sum;
  logic [PIX_W-1:0] avg;
  logic [PIX_W-1:0] hi_a, hi_b, hi;
  logic [PIX_W-1:0] lo_a, lo_b, lo;

  always_comb begin
    sum = {2'b00, win_i[WIN_TL]} + {2'b00, win_i[WIN_TR]}
        + {2'b00, win_i[WIN_BL]} + {2'b00, win_i[WIN_BR]};
    avg = sum[PIX_W+1:2];
    hi_a = (win_i[WIN_TL] > win_i[WIN_TR]) ? win_i[WIN_TL] : win_i[WIN_TR];
    hi_b = (win_i[WIN_BL] > win_i[WIN_BR]) ? win_i[WIN_BL] : win_i[WIN_BR];
    hi   = (hi_a > hi_b) ? hi_a : hi_b;
    lo_a = (win_i[WIN_TL] < win_i[WIN_TR]) ? win_i[WIN_TL] : win_i[WIN_TR];
    lo_b = (win_i[WIN_BL] < win_i[WIN_BR]) ? win_i[WIN_BL] : win_i[WIN_BR];
    lo   = (lo_a < lo_b) ? lo_a : lo_b;
    win_o = win_i;
    unique case (1'b1)
      (cmd_i == CMD_AVG): win_o = {4{avg}};
      (cmd_i == CMD_MAX): win_o = {4{hi}};
      (cmd_i == CMD_MIN): win_o = {4{lo}};
      (cmd_i == CMD_MIRX): begin
        win_o[WIN_TL] = win_i[WIN_BL];
        win_o[WIN_BL] = win_i[WIN_TL];
        win_o[WIN_TR] = win_i[WIN_BR];
        win_o[WIN_BR] = win_i[WIN_TR];
      end
      (cmd_i == CMD_MIRY): begin
        win_o[WIN_TL] = win_i[WIN_TR];
        win_o[WIN_TR] = win_i[WIN_TL];
        win_o[WIN_BL] = win_i[WIN_BR];
        win_o[WIN_BR] = win_i[WIN_BL];
      end
`ifdef LCD_CTRL_ROTATE_EN
      (cmd_i == CMD_ROT_CW): begin
        win_o[WIN_TR] = win_i[WIN_TL];
        win_o[WIN_BR] = win_i[WIN_TR];
        win_o[WIN_BL] = win_i[WIN_BR];
        win_o[WIN_TL] = win_i[WIN_BL];
      end
      (cmd_i == CMD_ROT_CCW): begin
        win_o[WIN_TL] = win_i[WIN_TR];
        win_o[WIN_TR] = win_i[WIN_BR];
        win_o[WIN_BR] = win_i[WIN_BL];
        win_o[WIN_BL] = win_i[WIN_TL];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller top: IROM load, command FSM, origin, pixel
// array, IRB write-out. Rotate support via LCD_CTRL_ROTATE_EN.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter  int PIX_W      = 8,
  parameter  int IMG_W_LOG2 = 3,
  parameter  int IMG_H_LOG2 = 3,
  localparam int ADDR_W     = IMG_W_LOG2 + IMG_H_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  output logic              IROM_EN,
  output logic [ADDR_W-1:0] IROM_A,
  input  logic [PIX_W-1:0]  IROM_Q,
  output logic              IRB_RW,
  output logic [ADDR_W-1:0] IRB_A,
  output logic [PIX_W-1:0]  IRB_D,
  output logic              busy,
  output logic              done
);

  localparam int N  = 1 << ADDR_W;
  localparam int XW = IMG_W_LOG2;
  localparam int YW = IMG_H_LOG2;

  localparam logic [ADDR_W:0] C_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] C_TWO = {{(ADDR_W-1){1'b0}}, 2'b10};
  localparam logic [ADDR_W:0] C_TOP = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] C_N   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_END = {1'b1, {(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [XW-1:0] X_MID = {1'b1, {(XW-1){1'b0}}};
  localparam logic [YW-1:0] Y_MID = {1'b1, {(YW-1){1'b0}}};
  localparam logic [XW-1:0] X_MIN = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_MIN = {{(YW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] irom_a_q, irom_a_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] irb_a_q, irb_a_d;
  logic [PIX_W-1:0]  irb_d_q, irb_d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;

  logic [PIX_W-1:0]  pix_q [N];
  logic              ld_we;
  logic              ex_we;
  logic [ADDR_W-1:0] ld_idx;
  logic [XW-1:0]     xm1;
  logic [YW-1:0]     ym1;

  logic [3:0][ADDR_W-1:0] win_idx;
  logic [3:0][PIX_W-1:0]  win_pix;
  logic [3:0][PIX_W-1:0]  win_new;

  // Data arriving now was addressed two load steps ago.
  assign ld_idx = cnt_q[ADDR_W-1:0] - C_TWO[ADDR_W-1:0];
  assign ex_we  = (state_q == S_EXEC);
  assign xm1    = x_q - 1'b1;
  assign ym1    = y_q - 1'b1;

  always_comb begin
    win_idx[WIN_TL] = {ym1, xm1};
    win_idx[WIN_TR] = {ym1, x_q};
    win_idx[WIN_BL] = {y_q, xm1};
    win_idx[WIN_BR] = {y_q, x_q};
    for (int i = 0; i < 4; i++) begin
      win_pix[i] = pix_q[win_idx[i]];
    end
  end

  lcd_win_alu #(
    .PIX_W (PIX_W)
  ) u_alu (
    .cmd_i (cmd_q),
    .win_i (win_pix),
    .win_o (win_new)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    irom_a_d = irom_a_q;
    rw_d     = rw_q;
    irb_a_d  = irb_a_q;
    irb_d_d  = irb_d_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cmd_d    = cmd_q;
    x_d      = x_q;
    y_d      = y_q;
    ld_we    = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == '0) en_d = 1'b0;
        if (cnt_q >= C_ONE && cnt_q <= C_TOP) irom_a_d = cnt_q[ADDR_W-1:0];
        if (cnt_q == C_N) en_d = 1'b1;
        if (cnt_q >= C_TWO) ld_we = 1'b1;
        if (cnt_q == C_END) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        unique case (1'b1)
          (cmd_q == CMD_WRITE): begin
            state_d = S_WRITE;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
          (cmd_q == CMD_UP):    if (y_q != Y_MIN) y_d = y_q - 1'b1;
          (cmd_q == CMD_DOWN):  if (y_q != '1) y_d = y_q + 1'b1;
          (cmd_q == CMD_LEFT):  if (x_q != X_MIN) x_d = x_q - 1'b1;
          (cmd_q == CMD_RIGHT): if (x_q != '1) x_d = x_q + 1'b1;
          default: ;
        endcase
      end
      S_WRITE: begin
        if (!cnt_q[ADDR_W]) begin
          rw_d    = 1'b0;
          irb_a_d = cnt_q[ADDR_W-1:0];
          irb_d_d = pix_q[cnt_q[ADDR_W-1:0]];
          cnt_d   = cnt_q + C_ONE;
        end else begin
          rw_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      en_q     <= 1'b1;
      irom_a_q <= '0;
      rw_q     <= 1'b1;
      irb_a_q  <= '0;
      irb_d_q  <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      cmd_q    <= '0;
      x_q      <= X_MID;
      y_q      <= Y_MID;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      irom_a_q <= irom_a_d;
      rw_q     <= rw_d;
      irb_a_q  <= irb_a_d;
      irb_d_q  <= irb_d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cmd_q    <= cmd_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we) pix_q[ld_idx] <= IROM_Q;
    if (ex_we) begin
      for (int i = 0; i < 4; i++) begin
        pix_q[win_idx[i]] <= win_new[i];
      end
    end
  end

  assign IROM_EN = en_q;
  assign IROM_A  = irom_a_q;
  assign IRB_RW  = rw_q;
  assign IRB_A   = irb_a_q;
  assign IRB_D   = irb_d_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: 8x8/8-bit instance plus a 16x16/10-bit
// instance, image model with an IRB write scoreboard.
module tb_lcd_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid;
  logic [3:0] cmd;
  logic       irom_en, irb_rw, busy, done;
  logic [5:0] irom_a, irb_a;
  logic [7:0] irom_q, irb_d;

  logic       rst2_n, cv2;
  logic [3:0] cmd2;
  logic       irom2_en, irb2_rw, busy2, done2;
  logic [7:0] irom2_a, irb2_a;
  logic [9:0] irom2_q, irb2_d;

  logic [7:0] rom  [64];
  logic [9:0] rom2 [256];

  int checks = 0;
  int errors = 0;
  int model [64];
  int mx, my;
  int exp_a_q[$];
  int exp_d_q[$];

  lcd_ctrl_param dut (
    .clk(clk), .reset(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_EN(irom_en), .IROM_A(irom_a), .IROM_Q(irom_q),
    .IRB_RW(irb_rw), .IRB_A(irb_a), .IRB_D(irb_d),
    .busy(busy), .done(done)
  );

  lcd_ctrl_param #(.PIX_W(10), .IMG_W_LOG2(4), .IMG_H_LOG2(4)) dut2 (
    .clk(clk), .reset(rst2_n), .cmd(cmd2), .cmd_valid(cv2),
    .IROM_EN(irom2_en), .IROM_A(irom2_a), .IROM_Q(irom2_q),
    .IRB_RW(irb2_rw), .IRB_A(irb2_a), .IRB_D(irb2_d),
    .busy(busy2), .done(done2)
  );

  always @(posedge clk) irom_q  <= rom[irom_a];
  always @(posedge clk) irom2_q <= rom2[irom2_a];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_init;
    for (int k = 0; k < 64; k++) model[k] = rom[k];
    mx = 4;
    my = 4;
    exp_a_q.delete();
    exp_d_q.delete();
  endtask

  task automatic apply_model(input int c);
    int tl, tr, bl, br, a, b, cc, d, t;
    tl = (my - 1) * 8 + (mx - 1);
    tr = tl + 1;
    bl = tl + 8;
    br = bl + 1;
    a = model[tl]; b = model[tr]; cc = model[bl]; d = model[br];
    case (c)
      1: if (my > 1) my--;
      2: if (my < 7) my++;
      3: if (mx > 1) mx--;
      4: if (mx < 7) mx++;
      5: begin
        t = (a + b + cc + d) / 4;
        model[tl] = t; model[tr] = t; model[bl] = t; model[br] = t;
      end
      6: begin
        model[tl] = cc; model[bl] = a; model[tr] = d; model[br] = b;
      end
      7: begin
        model[tl] = b; model[tr] = a; model[bl] = d; model[br] = cc;
      end
      8, 9: begin
        t = a;
        if ((c == 8) ? (b > t) : (b < t)) t = b;
        if ((c == 8) ? (cc > t) : (cc < t)) t = cc;
        if ((c == 8) ? (d > t) : (d < t)) t = d;
        model[tl] = t; model[tr] = t; model[bl] = t; model[br] = t;
      end
`ifdef LCD_CTRL_ROTATE_EN
      10: begin
        model[tr] = a; model[br] = b; model[bl] = d; model[tl] = cc;
      end
      11: begin
        model[tl] = b; model[tr] = d; model[br] = cc; model[bl] = a;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b required 0 within %0d cycles", busy, n);
    end
  endtask

  task automatic start_dut;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 4'd0;
    tick;
    tick;
    rst_n = 1'b1;
    model_init();
    wait_idle();
  endtask

  task automatic do_cmd(input int c);
    wait_idle();
    cmd = 4'(c);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept cmd=%0d busy=%b required 1", c, busy);
    end
    apply_model(c);
    if (c == 0) begin
      for (int k = 0; k < 64; k++) begin
        exp_a_q.push_back(k);
        exp_d_q.push_back(model[k]);
      end
    end else begin
      tick;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_pulse cmd=%0d busy=%b required 0", c, busy);
      end
    end
  endtask

  task automatic do_write(input string tag);
    int got, ea, ed;
    got = 0;
    do_cmd(0);
    for (int i = 0; i < 80; i++) begin
      tick;
      if (irb_rw === 1'b0) begin
        checks++;
        if (exp_a_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra write addr=%0d required none", tag, irb_a);
        end else begin
          ea = exp_a_q.pop_front();
          ed = exp_d_q.pop_front();
          if (irb_a !== 6'(ea) || irb_d !== 8'(ed)) begin
            errors++;
            $display("FAIL %s pix addr=%0d data=%0d required addr=%0d data=%0d",
                     tag, irb_a, irb_d, ea, ed);
          end
        end
        got++;
      end else if (got == 64) begin
        break;
      end
    end
    checks++;
    if (got != 64) begin
      errors++;
      $display("FAIL %s write_count got=%0d required 64", tag, got);
    end
    checks++;
    if (done !== 1'b1 || irb_rw !== 1'b1) begin
      errors++;
      $display("FAIL %s done done=%b rw=%b required 1 1", tag, done, irb_rw);
    end
    cmd = 4'd5;
    cmd_valid = 1'b1;
    repeat (3) tick;
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b1 || irb_rw !== 1'b1) begin
      errors++;
      $display("FAIL %s done_hold busy=%b done=%b rw=%b required 1 1 1",
               tag, busy, done, irb_rw);
    end
  endtask

  task automatic test_reset;
    int ea, ee, eb;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 4'd0;
    tick;
    tick;
    checks++;
    if (irom_en !== 1'b1 || irom_a !== 6'd0 || irb_rw !== 1'b1 || irb_a !== 6'd0 ||
        irb_d !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals en=%b a=%0d rw=%b ia=%0d d=%0d busy=%b done=%b required 1 0 1 0 0 1 0",
               irom_en, irom_a, irb_rw, irb_a, irb_d, busy, done);
    end
    rst_n = 1'b1;
    model_init();
    for (int c = 0; c <= 65; c++) begin
      tick;
      ee = (c <= 63) ? 0 : 1;
      ea = (c <= 63) ? c : 63;
      eb = (c <= 64) ? 1 : 0;
      checks++;
      if (irom_en !== 1'(ee) || irom_a !== 6'(ea) || busy !== 1'(eb)) begin
        errors++;
        $display("FAIL load cycle=%0d en=%b a=%0d busy=%b required %0d %0d %0d",
                 c, irom_en, irom_a, busy, ee, ea, eb);
      end
    end
  endtask

  task automatic test_write_plain;
    do_write("write_plain");
  endtask

  task automatic test_average;
    start_dut();
    do_cmd(5);
    do_write("average");
  endtask

  task automatic test_shift_ops;
    start_dut();
    repeat (5) do_cmd(1);
    do_cmd(6);
    repeat (9) do_cmd(4);
    do_cmd(8);
    do_cmd(2);
    do_cmd(7);
    do_cmd(3);
    do_cmd(9);
    do_write("shift_ops");
  endtask

  task automatic test_back_to_back;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    tick;
    tick;
    cmd = 4'd6;
    cmd_valid = 1'b1;
    rst_n = 1'b1;
    model_init();
    repeat (66) tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_load busy=%b required 0", busy);
    end
    tick;
    apply_model(6);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_accept busy=%b required 1", busy);
    end
    tick;
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_exec busy=%b required 0", busy);
    end
    do_cmd(3);
    do_cmd(5);
    do_cmd(5);
    do_write("back_to_back");
  endtask

  task automatic test_rotate;
    start_dut();
    do_cmd(10);
    do_cmd(11);
    do_cmd(4);
    do_cmd(10);
    do_cmd(13);
    do_write("rotate_nop");
  endtask

  task automatic test_reset_mid_write;
    int n;
    start_dut();
    do_cmd(0);
    exp_a_q.delete();
    exp_d_q.delete();
    n = 0;
    while (!(irb_rw === 1'b0 && irb_a === 6'd20) && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (irb_a !== 6'd20) begin
      errors++;
      $display("FAIL mid_write_reach a=%0d required 20", irb_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (irb_rw !== 1'b1 || irb_a !== 6'd0 || irb_d !== 8'd0 || busy !== 1'b1 ||
        done !== 1'b0 || irom_en !== 1'b1 || irom_a !== 6'd0) begin
      errors++;
      $display("FAIL mid_write_reset rw=%b a=%0d d=%0d busy=%b done=%b en=%b ra=%0d required 1 0 0 1 0 1 0",
               irb_rw, irb_a, irb_d, busy, done, irom_en, irom_a);
    end
    tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if (irom_en !== 1'b0 || irom_a !== 6'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reload_start en=%b a=%0d done=%b required 0 0 0", irom_en, irom_a, done);
    end
    wait_idle();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reload_done done=%b required 0", done);
    end
  endtask

  task automatic test_wide;
    int m2 [256];
    int n, got, t, ea, ed;
    cv2 = 1'b0;
    cmd2 = 4'd0;
    rst2_n = 1'b0;
    tick;
    tick;
    checks++;
    if (irb2_rw !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0 || irom2_en !== 1'b1) begin
      errors++;
      $display("FAIL wide_reset rw=%b busy=%b done=%b en=%b required 1 1 0 1",
               irb2_rw, busy2, done2, irom2_en);
    end
    rst2_n = 1'b1;
    n = 0;
    while (busy2 !== 1'b0 && n < 400) begin
      tick;
      n++;
    end
    checks++;
    if (n != 258) begin
      errors++;
      $display("FAIL wide_load cycles=%0d required 258", n);
    end
    for (int k = 0; k < 256; k++) m2[k] = rom2[k];
    t = (m2[119] + m2[120] + m2[135] + m2[136]) / 4;
    m2[119] = t; m2[120] = t; m2[135] = t; m2[136] = t;
    cmd2 = 4'd5;
    cv2 = 1'b1;
    tick;
    cv2 = 1'b0;
    tick;
    cmd2 = 4'd0;
    cv2 = 1'b1;
    tick;
    cv2 = 1'b0;
    exp_a_q.delete();
    exp_d_q.delete();
    for (int k = 0; k < 256; k++) begin
      exp_a_q.push_back(k);
      exp_d_q.push_back(m2[k]);
    end
    got = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (irb2_rw === 1'b0) begin
        checks++;
        if (exp_a_q.size() == 0) begin
          errors++;
          $display("FAIL wide extra write addr=%0d required none", irb2_a);
        end else begin
          ea = exp_a_q.pop_front();
          ed = exp_d_q.pop_front();
          if (irb2_a !== 8'(ea) || irb2_d !== 10'(ed)) begin
            errors++;
            $display("FAIL wide pix addr=%0d data=%0d required addr=%0d data=%0d",
                     irb2_a, irb2_d, ea, ed);
          end
        end
        got++;
      end else if (got == 256) begin
        break;
      end
    end
    checks++;
    if (got != 256 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL wide_done count=%0d done=%b required 256 1", got, done2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 4'd0;
    cv2 = 1'b0;
    cmd2 = 4'd0;
    for (int k = 0; k < 64; k++) rom[k] = 8'(k);
    for (int k = 0; k < 256; k++) rom2[k] = 10'((k * 37 + 5) % 1024);
    rom2[119] = 10'd1023;
    rom2[120] = 10'd1023;
    rom2[135] = 10'd1023;
    rom2[136] = 10'd1022;
    test_reset();
    test_write_plain();
    test_average();
    test_shift_ops();
    test_back_to_back();
    test_rotate();
    test_reset_mid_write();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
